// File: rtl/axi_rom_slave.sv
// axi_rom_slave: AXI3 read-only responder in front of a synchronous single-port memory.
// Serves one AR burst at a time (INCR/WRAP/FIXED) with SLVERR/DECERR beat responses.
module axi_rom_slave #(
    parameter int unsigned ID_W   = 4,
    parameter logic [31:0] BASE   = 32'h1FC0_0000,
    parameter int unsigned MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    // AR channel
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [3:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    // R channel
    output logic [ID_W-1:0]   s_rid,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    // Memory port
    output logic              mem_en,
    output logic [MEM_AW-3:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StFetch, StResp} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q;
    logic [31:0]      addr_q;
    logic [3:0]       len_q;
    logic [2:0]       size_q;
    logic [1:0]       burst_q;
    logic             slverr_q;
    logic [3:0]       cnt_q;

    logic             ar_bad;
    logic             last_beat;
    logic             decerr;
    logic [1:0]       beat_resp;
    logic [31:0]      nb;
    logic [31:0]      wrap_mask;
    logic [31:0]      next_addr;

    // Whole-burst protocol errors, decided once from the AR payload
    always_comb begin
        ar_bad = (s_arburst == 2'b11) || (s_arsize > 3'd2) ||
                 ((s_arburst == 2'b10) &&
                  !((s_arlen == 4'd1) || (s_arlen == 4'd3) ||
                    (s_arlen == 4'd7) || (s_arlen == 4'd15)));
    end

    // Per-beat response and next beat address
    always_comb begin
        last_beat = (cnt_q == len_q);
        decerr    = (addr_q[31:MEM_AW] != BASE[31:MEM_AW]);
        if (slverr_q) begin
            beat_resp = 2'b10;
        end else if (decerr) begin
            beat_resp = 2'b11;
        end else begin
            beat_resp = 2'b00;
        end
        nb        = 32'd1 << size_q;
        wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + nb) & wrap_mask);
            // INCR, and reserved bursts still step so the beat count is honoured
            default: next_addr = addr_q + nb;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (s_arvalid) state_d = StFetch;
            StFetch: state_d = StResp;
            StResp: begin
                if (s_rready) begin
                    state_d = last_beat ? StIdle : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst context: latched on AR accept, stepped on each non-final beat handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            slverr_q <= 1'b0;
            cnt_q    <= '0;
        end else if ((state_q == StIdle) && s_arvalid) begin
            id_q     <= s_arid;
            addr_q   <= s_araddr;
            len_q    <= s_arlen;
            size_q   <= s_arsize;
            burst_q  <= s_arburst;
            slverr_q <= ar_bad;
            cnt_q    <= '0;
        end else if ((state_q == StResp) && s_rready && !last_beat) begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= next_addr;
        end
    end

    // Outputs decoded from state; memory data is only forwarded on OKAY beats
    always_comb begin
        s_arready = (state_q == StIdle);
        mem_en    = (state_q == StFetch) && (beat_resp == 2'b00);
        s_rvalid  = (state_q == StResp);
        s_rlast   = (state_q == StResp) && last_beat;
        s_rresp   = (state_q == StResp) ? beat_resp : 2'b00;
        s_rdata   = ((state_q == StResp) && (beat_resp == 2'b00)) ? mem_rdata : 32'h0;
        s_rid     = id_q;
        mem_addr  = addr_q[MEM_AW-1:2];
    end

endmodule

// File: tb/tb_axi_rom_slave.sv
// tb_axi_rom_slave: directed bench with a beat scoreboard for axi_rom_slave.
module tb_axi_rom_slave;

    localparam int unsigned ID_W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ID_W-1:0] s_arid = '0;
    logic [31:0]     s_araddr = '0;
    logic [3:0]      s_arlen = '0;
    logic [2:0]      s_arsize = '0;
    logic [1:0]      s_arburst = '0;
    logic            s_arvalid = 1'b0;
    logic            s_arready;
    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready = 1'b0;
    logic            mem_en;
    logic [13:0]     mem_addr;
    logic [31:0]     mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t           exp_q[$];
    logic [13:0]     mem_log[$];
    logic [ID_W-1:0] cur_id;
    int              first_rv;

    axi_rom_slave dut (
        .clk       (clk),
        .rst       (rst),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [13:0] i);
        if (i == 14'd0) return 32'hDEAD_BEEF;
        return {2'b01, i, 2'b10, ~i};
    endfunction

    // Synchronous memory model: data appears the cycle after mem_en and holds
    always_ff @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expect(input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
        logic        slv;
        logic [31:0] a, nb, mask;
        beat_t       b;
        slv = (burst == 2'b11) || (size > 3'd2) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        a    = addr;
        nb   = 32'd1 << size;
        mask = (32'(len) + 32'd1) * nb - 32'd1;
        for (int i = 0; i <= int'(len); i++) begin
            b.addr = a;
            b.resp = slv ? 2'b10 : ((a[31:16] != 16'h1FC0) ? 2'b11 : 2'b00);
            b.data = (b.resp == 2'b00) ? mem_word(a[15:2]) : 32'h0;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (burst == 2'b00) a = a;
            else if (burst == 2'b10) a = (a & ~mask) | ((a + nb) & mask);
            else a = a + nb;
        end
    endtask

    // Called at a negedge; returns at the negedge that starts cycle 1 after the handshake
    task automatic issue_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, output int waitc);
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = len;
        s_arsize  = size;
        s_arburst = burst;
        s_arvalid = 1'b1;
        waitc     = 0;
        while (!s_arready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("ar_accept_timeout", 64'(waitc < 50), 64'd1);
        cur_id = id;
        exp_q.delete();
        mem_log.delete();
        build_expect(addr, len, size, burst);
        @(negedge clk);
        s_arvalid = 1'b0;
    endtask

    // mode 0: rready held 1; mode 1: pseudo-random rready.
    // raise_beat >= 0: after that many beats, present the next AR (payload in nxt).
    // reset_beat >= 0: assert reset while that beat is on the bus.
    task automatic serve(input int nbeats, input int mode, input int raise_beat,
                         input logic [ID_W+44:0] nxt, input int reset_beat);
        int    cyc, got;
        bit    done, raised;
        beat_t e;
        cyc = 1; got = 0; done = 0; raised = 0; first_rv = -1;
        while (!done && cyc < 400) begin
            if (reset_beat >= 0 && got == reset_beat && s_rvalid) begin
                rst = 1'b1;
                #1;
                chk("rst_async_rvalid", 64'(s_rvalid), 64'd0);
                chk("rst_async_arready", 64'(s_arready), 64'd1);
                chk("rst_async_mem_en", 64'(mem_en), 64'd0);
                @(negedge clk);
                chk("rst_hold_rvalid", 64'(s_rvalid), 64'd0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (s_rvalid) begin
                if (first_rv < 0) first_rv = cyc;
                chk("r_mem_en_quiet", 64'(mem_en), 64'd0);
                if (raised) chk("ar_blocked", 64'(s_arready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("rid", 64'(s_rid), 64'(cur_id));
                    chk("rdata", 64'(s_rdata), 64'(e.data));
                    chk("rresp", 64'(s_rresp), 64'(e.resp));
                    chk("rlast", 64'(s_rlast), 64'(e.last));
                end
            end
            if (mem_en) begin
                mem_log.push_back(mem_addr);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr[15:2]));
                    chk("mem_en_okay_only", 64'(e.resp), 64'd0);
                end
            end
            s_rready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (s_rvalid && s_rready) begin
                if (mode == 0) chk("beat_cycle", 64'(cyc), 64'(2 + 2 * got));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.last) done = 1;
                end
                got++;
            end
            if (raise_beat >= 0 && got == raise_beat && !raised) begin
                {s_arid, s_araddr, s_arlen, s_arsize, s_arburst} = nxt;
                s_arvalid = 1'b1;
                raised = 1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", 64'(got), 64'(nbeats));
        chk("arready_after_last", 64'(s_arready), 64'd1);
    endtask

    initial begin
        int w;
        logic [ID_W+44:0] none;
        none = '0;
        cur_id = '0;

        // Reset state
        @(negedge clk);
        chk("rst_arready", 64'(s_arready), 64'd1);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_rlast", 64'(s_rlast), 64'd0);
        chk("rst_rresp", 64'(s_rresp), 64'd0);
        chk("rst_rid", 64'(s_rid), 64'd0);
        chk("rst_rdata", 64'(s_rdata), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single beat
        issue_ar(4'h5, 32'h1FC0_0000, 4'd0, 3'd2, 2'b01, w);
        chk("single_mem_en_c1", 64'(mem_en), 64'd1);
        serve(1, 0, -1, none, -1);
        chk("single_rvalid_cycle", 64'(first_rv), 64'd2);

        // INCR 16 beats
        issue_ar(4'hA, 32'h1FC0_0100, 4'd15, 3'd2, 2'b01, w);
        serve(16, 0, -1, none, -1);
        chk("incr16_mem_cnt", 64'(mem_log.size()), 64'd16);
        chk("incr16_first_addr", 64'(mem_log[0]), 64'h40);
        chk("incr16_last_addr", 64'(mem_log[15]), 64'h4F);

        // WRAP len=3
        issue_ar(4'h3, 32'h1FC0_0018, 4'd3, 3'd2, 2'b10, w);
        serve(4, 0, -1, none, -1);
        chk("wrap_a0", 64'(mem_log[0]), 64'(32'h18 >> 2));
        chk("wrap_a1", 64'(mem_log[1]), 64'(32'h1C >> 2));
        chk("wrap_a2", 64'(mem_log[2]), 64'(32'h10 >> 2));
        chk("wrap_a3", 64'(mem_log[3]), 64'(32'h14 >> 2));

        // WRAP len=2 is illegal: SLVERR, no memory reads
        issue_ar(4'h7, 32'h1FC0_0020, 4'd2, 3'd2, 2'b10, w);
        serve(3, 0, -1, none, -1);
        chk("wrap_bad_no_mem", 64'(mem_log.size()), 64'd0);

        // INCR crossing the region top: two OKAY then two DECERR
        issue_ar(4'h1, 32'h1FC0_FFF8, 4'd3, 3'd2, 2'b01, w);
        serve(4, 0, -1, none, -1);
        chk("dec_mem_cnt", 64'(mem_log.size()), 64'd2);
        chk("dec_last_ok_addr", 64'(mem_log[1]), 64'h3FFF);

        // arsize=3 is unsupported: SLVERR
        issue_ar(4'h2, 32'h1FC0_0040, 4'd1, 3'd3, 2'b01, w);
        serve(2, 0, -1, none, -1);
        chk("size3_no_mem", 64'(mem_log.size()), 64'd0);

        // Backpressure with a second AR held valid from beat 3
        issue_ar(4'h9, 32'h1FC0_0200, 4'd7, 3'd2, 2'b01, w);
        serve(8, 1, 3, {4'hC, 32'h1FC0_0300, 4'd1, 3'd2, 2'b01}, -1);
        chk("bp_mem_cnt", 64'(mem_log.size()), 64'd8);
        issue_ar(4'hC, 32'h1FC0_0300, 4'd1, 3'd2, 2'b01, w);
        chk("held_ar_immediate", 64'(w), 64'd0);
        serve(2, 0, -1, none, -1);

        // Reset during beat 2 of an 8-beat burst, then a fresh burst from cnt=0
        issue_ar(4'h4, 32'h1FC0_0400, 4'd7, 3'd2, 2'b01, w);
        serve(8, 0, -1, none, 2);
        chk("post_rst_arready", 64'(s_arready), 64'd1);
        issue_ar(4'h6, 32'h1FC0_0500, 4'd2, 3'd2, 2'b01, w);
        serve(3, 0, -1, none, -1);
        chk("post_rst_first_addr", 64'(mem_log[0]), 64'(32'h500 >> 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_rom_slave.md
# axi_rom_slave

AXI3 read-only responder serving instruction/boot fetches from a synchronous single-port memory (boot ROM or preloaded RAM). It is the far end of the master-side read arbiter's `m_ar*`/`m_r*` bundle. It accepts one AR request at a time and returns the burst on R with INCR/WRAP/FIXED address generation, backpressure and error responses. Write channels are not implemented.

## Interface
Parameters:
- `ID_W`, 4, AXI ID width; `arid` is echoed on `rid`.
- `BASE`, 32'h1FC0_0000, region base; bits `[31:MEM_AW]` are compared.
- `MEM_AW`, 16, log2 of region size in bytes (word-addressed memory of `2^(MEM_AW-2)` entries).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous and active-high.
- `s_arid` in ID_W / `s_araddr` in 32 / `s_arlen` in 4 / `s_arsize` in 3 / `s_arburst` in 2 — AR payload.
- `s_arvalid` in 1, `s_arready` out 1 — AR handshake.
- `s_rid` out ID_W, `s_rdata` out 32, `s_rresp` out 2, `s_rlast` out 1 — R payload.
- `s_rvalid` out 1, `s_rready` in 1 — R handshake.
- `mem_en` out 1 — memory read strobe.
- `mem_addr` out MEM_AW-2 — word address, `addr[MEM_AW-1:2]`.
- `mem_rdata` in 32 — valid the cycle after `mem_en`, held until the next `mem_en`.

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE: `s_arready=1`. On `s_arvalid`, latch id, addr, len, size and burst, clear beat counter `cnt` to 0, and go to FETCH.
- FETCH: one cycle. `mem_en=1` only if the current beat is OKAY (see below), then go to RESP.
- RESP: `s_rvalid=1`, `s_rlast=(cnt==len)`.
  - On `s_rready` with last: go to IDLE.
  - On `s_rready` otherwise: `cnt+1`, advance addr, go to FETCH.
- `s_rdata` = `mem_rdata` for OKAY beats, 32'h0 for error beats. `s_rid` = latched id for the whole burst.
- Response per beat, evaluated on the current beat address, highest priority first:
  - `s_arburst==2'b11`, `s_arsize>2`, or WRAP with len not in {1,3,7,15}: SLVERR (2'b10) for all beats.
  - `addr[31:MEM_AW] != BASE[31:MEM_AW]`: DECERR (2'b11).
  - Otherwise: OKAY (2'b00).
- Address advance, with `nb = 1<<size`:
  - FIXED: unchanged.
  - INCR: `addr+nb`, modulo 2^32 (wrap-around across 4 GiB allowed).
  - WRAP: `mask=(len+1)*nb-1`, `addr=(addr&~mask)|((addr+nb)&mask)`.
  - Error bursts still step the address so the burst length is honoured.
- Unaligned start addresses are not realigned. `mem_addr` drops `addr[1:0]`, and the full word is returned.
- Exactly `len+1` R beats are returned per accepted AR. No new AR is accepted until the last beat has handshaked.

## Timing
- Reset values: `s_arready=1` (state IDLE), `s_rvalid=0`, `s_rlast=0`, `s_rresp=0`, `s_rid=0`, `s_rdata=0`, `mem_en=0`, `mem_addr=0`. Reset asserted mid-burst aborts the burst immediately; no further R beats are produced.
- AR handshake in cycle 0. `mem_en` in cycle 1. `s_rvalid` from cycle 2.
- With `s_rready` held 1, one beat every 2 cycles. The next AR can be accepted in the cycle after the last-beat handshake.
- While `s_rvalid=1 && !s_rready`, all R outputs are stable and `mem_en=0`.
- `s_arready` is 0 in FETCH and RESP. An `s_arvalid` raised in those states waits, and is accepted in the first IDLE cycle.
- `s_rvalid` never depends combinationally on `s_rready`. `s_arready` never depends on `s_arvalid`.

## Test plan
- Single beat: araddr=0x1FC0_0000, len=0, size=2, INCR, mem word0=0xDEADBEEF. Required: rvalid in cycle 2, rdata=0xDEADBEEF, rresp=0, rlast=1, rid=arid, arready back to 1 in cycle 3.
- INCR 16-beat, len=15 from 0x1FC0_0100 with rready=1. Required: mem_addr 0x40..0x4F, beats every 2 cycles, rlast only on beat 15.
- WRAP len=3, size=2, start 0x1FC0_0018. Required: addresses 0x18, 0x1C, 0x10, 0x14. A WRAP with len=2 returns 3 SLVERR beats with rdata=0 and mem_en never asserted.
- INCR len=3 from 0x1FC0_FFF8 (MEM_AW=16). Required: beats 0-1 OKAY, beats 2-3 DECERR at 0x1FC1_0000/0x1FC1_0004. arsize=3 gives SLVERR for all beats.
- Backpressure: rready toggled 0/1 pseudo-randomly across an 8-beat burst. Required: every beat held stable while stalled, no beat lost or duplicated, mem_en=0 during stalls, a second AR held valid is accepted only after the last beat.
- Reset asserted during beat 2 of an 8-beat burst. Required: rvalid=0 and arready=1 asynchronously; the next AR after deassertion is served from cnt=0.
